// File: rtl/i2c_slave_responder.sv
// I2C target with a small register file: address match, register pointer, auto-incrementing
// burst writes and reads. SCL/SDA are oversampled on clk; SDA is driven open-drain.
module i2c_slave_responder #(
    parameter logic [6:0] DEVICE_ADDR = 7'h50,
    parameter int         REG_AW      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_scl,
    inout  wire               io_sda,
    input  logic [REG_AW-1:0] i_dbg_addr,
    output logic [7:0]        o_dbg_data,
    output logic              o_wr_en,
    output logic [REG_AW-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic              o_busy
);
    localparam int DEPTH = 2 ** REG_AW;

    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
    } state_t;

    state_t            state_reg;
    logic              scl_meta_reg, scl_sync_reg, scl_prev_reg;
    logic              sda_meta_reg, sda_sync_reg, sda_prev_reg;
    logic              drive_reg;
    logic [2:0]        bit_cnt_reg;
    logic [6:0]        shift_reg;
    logic [7:0]        tx_reg;
    logic              ack_seen_reg;
    logic              rw_reg;
    logic [REG_AW-1:0] ptr_reg;
    logic [7:0]        regs [DEPTH];

    logic       scl_rise, scl_fall, start_cond, stop_cond, byte_done;
    logic [7:0] byte_in;

    assign io_sda     = drive_reg ? 1'b0 : 1'bz;
    assign o_dbg_data = regs[i_dbg_addr];

    assign scl_rise   = scl_sync_reg & ~scl_prev_reg;
    assign scl_fall   = ~scl_sync_reg & scl_prev_reg;
    assign start_cond = scl_sync_reg & scl_prev_reg & sda_prev_reg & ~sda_sync_reg;
    assign stop_cond  = scl_sync_reg & scl_prev_reg & ~sda_prev_reg & sda_sync_reg;
    assign byte_in    = {shift_reg, sda_sync_reg};
    assign byte_done  = scl_rise && (bit_cnt_reg == 3'd7);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {scl_meta_reg, scl_sync_reg, scl_prev_reg} <= 3'b111;
            {sda_meta_reg, sda_sync_reg, sda_prev_reg} <= 3'b111;
        end else begin
            scl_meta_reg <= i_scl;
            scl_sync_reg <= scl_meta_reg;
            scl_prev_reg <= scl_sync_reg;
            sda_meta_reg <= io_sda;
            sda_sync_reg <= sda_meta_reg;
            sda_prev_reg <= sda_sync_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            drive_reg    <= 1'b0;
            bit_cnt_reg  <= 3'd0;
            shift_reg    <= 7'd0;
            tx_reg       <= 8'h00;
            ack_seen_reg <= 1'b0;
            rw_reg       <= 1'b0;
            ptr_reg      <= '0;
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= 8'h00;
            o_busy       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
        end else begin
            o_wr_en <= 1'b0;
            if (scl_rise) begin
                shift_reg   <= byte_in[6:0];
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
            // Bus conditions override whatever bit handling the current state would do.
            if (stop_cond) begin
                state_reg <= IDLE;
                o_busy    <= 1'b0;
                drive_reg <= 1'b0;
            end else if (start_cond) begin
                state_reg    <= DEV_ADDR;
                bit_cnt_reg  <= 3'd0;
                drive_reg    <= 1'b0;
                ack_seen_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: ;
                    DEV_ADDR: begin
                        if (byte_done) begin
                            if (byte_in[7:1] == DEVICE_ADDR) begin
                                state_reg <= DEV_ACK;
                                o_busy    <= 1'b1;
                                rw_reg    <= byte_in[0];
                            end else begin
                                state_reg <= IDLE;
                                o_busy    <= 1'b0;
                            end
                        end
                    end
                    REG_ADDR: begin
                        if (byte_done) begin
                            ptr_reg   <= byte_in[REG_AW-1:0];
                            state_reg <= REG_ACK;
                        end
                    end
                    WR_DATA: begin
                        if (byte_done) begin
                            regs[ptr_reg] <= byte_in;
                            o_wr_en       <= 1'b1;
                            o_wr_addr     <= ptr_reg;
                            o_wr_data     <= byte_in;
                            ptr_reg       <= ptr_reg + 1'b1;
                            state_reg     <= WR_ACK;
                        end
                    end
                    // Pull SDA low on the fall ending bit 8, let go on the fall ending bit 9.
                    DEV_ACK, REG_ACK, WR_ACK: begin
                        if (scl_rise) begin
                            ack_seen_reg <= 1'b1;
                            bit_cnt_reg  <= 3'd0;
                        end else if (scl_fall) begin
                            if (!ack_seen_reg) begin
                                drive_reg <= 1'b1;
                            end else begin
                                ack_seen_reg <= 1'b0;
                                if (state_reg == DEV_ACK && rw_reg) begin
                                    state_reg <= RD_DATA;
                                    tx_reg    <= regs[ptr_reg];
                                    drive_reg <= ~regs[ptr_reg][7];
                                end else begin
                                    state_reg <= (state_reg == DEV_ACK) ? REG_ADDR : WR_DATA;
                                    drive_reg <= 1'b0;
                                end
                            end
                        end
                    end
                    RD_DATA: begin
                        if (scl_rise) begin
                            tx_reg <= {tx_reg[6:0], 1'b0};
                            if (bit_cnt_reg == 3'd7) state_reg <= RD_ACK;
                        end else if (scl_fall) begin
                            drive_reg <= ~tx_reg[7];
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            bit_cnt_reg <= 3'd0;
                            ptr_reg     <= ptr_reg + 1'b1;
                            if (sda_sync_reg) begin
                                state_reg <= IDLE;
                                o_busy    <= 1'b0;
                            end else begin
                                ack_seen_reg <= 1'b1;
                            end
                        end else if (scl_fall) begin
                            if (!ack_seen_reg) begin
                                drive_reg <= 1'b0;
                            end else begin
                                ack_seen_reg <= 1'b0;
                                state_reg    <= RD_DATA;
                                tx_reg       <= regs[ptr_reg];
                                drive_reg    <= ~regs[ptr_reg][7];
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: a bit-banged I2C master exercises writes, reads, wrap, mismatch and aborts.
module tb_i2c_slave_responder;
    localparam int Q = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_oe = 1'b0;
    logic [3:0] dbg_addr = 4'd0;
    logic [7:0] dbg_data;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    wire        sda_bus;

    pullup (sda_bus);
    assign sda_bus = m_oe ? 1'b0 : 1'bz;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int drove_cnt = 0;
    logic [3:0] last_addr = 4'd0;
    logic [7:0] last_data = 8'h00;

    i2c_slave_responder dut (
        .clk(clk), .rst_n(rst_n), .i_scl(scl), .io_sda(sda_bus),
        .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data), .o_wr_en(wr_en),
        .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en) begin
            wr_cnt    <= wr_cnt + 1;
            last_addr <= wr_addr;
            last_data <= wr_data;
        end
        if (sda_bus === 1'b0 && !m_oe) drove_cnt <= drove_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wq();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_oe = 1'b0; wq(); scl = 1'b1; wq();
        m_oe = 1'b1; wq(); scl = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        m_oe = 1'b1; wq(); scl = 1'b1; wq(); m_oe = 1'b0; wq();
    endtask

    task automatic write_bit(input logic b);
        m_oe = ~b; wq(); scl = 1'b1; wq(); wq(); scl = 1'b0; wq();
    endtask

    task automatic read_bit(output logic b);
        m_oe = 1'b0; wq(); scl = 1'b1; wq(); b = sda_bus; wq(); scl = 1'b0; wq();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    task automatic peek(input logic [3:0] a, output logic [7:0] d);
        dbg_addr = a; #1; d = dbg_data;
    endtask

    initial begin
        logic ack;
        logic [7:0] d;
        int n0, dr0;

        repeat (4) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_sda", 32'(sda_bus), 32'd1);
        rst_n = 1'b1;
        wq();
        peek(4'd3, d);
        chk("rst_reg3", 32'(d), 32'd0);

        // 1: single write
        n0 = wr_cnt;
        i2c_start();
        write_byte(8'hA0, ack); chk("t1_ack_dev", 32'(ack), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        write_byte(8'h03, ack); chk("t1_ack_reg", 32'(ack), 32'd0);
        write_byte(8'hA5, ack); chk("t1_ack_data", 32'(ack), 32'd0);
        i2c_stop(); wq();
        chk("t1_wr_count", 32'(wr_cnt - n0), 32'd1);
        chk("t1_wr_addr", 32'(last_addr), 32'd3);
        chk("t1_wr_data", 32'(last_data), 32'hA5);
        peek(4'd3, d); chk("t1_reg3", 32'(d), 32'hA5);
        chk("t1_busy_end", 32'(busy), 32'd0);

        // 2: address mismatch
        n0 = wr_cnt; dr0 = drove_cnt;
        i2c_start();
        write_byte(8'hA2, ack); chk("t2_ack_dev", 32'(ack), 32'd1);
        chk("t2_busy", 32'(busy), 32'd0);
        write_byte(8'h03, ack); chk("t2_ack_reg", 32'(ack), 32'd1);
        write_byte(8'h55, ack); chk("t2_ack_data", 32'(ack), 32'd1);
        i2c_stop(); wq();
        chk("t2_drove", 32'(drove_cnt - dr0), 32'd0);
        chk("t2_wr_count", 32'(wr_cnt - n0), 32'd0);
        peek(4'd3, d); chk("t2_reg3", 32'(d), 32'hA5);

        // 3: random read via repeated START
        i2c_start();
        write_byte(8'hA0, ack); chk("t3_ack_dev", 32'(ack), 32'd0);
        write_byte(8'h03, ack); chk("t3_ack_reg", 32'(ack), 32'd0);
        i2c_start();
        write_byte(8'hA1, ack); chk("t3_ack_rd", 32'(ack), 32'd0);
        read_byte(d, 1'b1); chk("t3_rd_byte", 32'(d), 32'hA5);
        dr0 = drove_cnt;
        wq();
        chk("t3_busy_nack", 32'(busy), 32'd0);
        i2c_stop(); wq();
        chk("t3_released", 32'(drove_cnt - dr0), 32'd0);

        // 4: burst write wrapping 15 -> 0
        n0 = wr_cnt;
        i2c_start();
        write_byte(8'hA0, ack); write_byte(8'h0F, ack);
        write_byte(8'h11, ack); chk("t4_ack_d0", 32'(ack), 32'd0);
        write_byte(8'h22, ack); chk("t4_ack_d1", 32'(ack), 32'd0);
        i2c_stop(); wq();
        chk("t4_wr_count", 32'(wr_cnt - n0), 32'd2);
        chk("t4_last_addr", 32'(last_addr), 32'd0);
        chk("t4_last_data", 32'(last_data), 32'h22);
        peek(4'd15, d); chk("t4_reg15", 32'(d), 32'h11);
        peek(4'd0, d); chk("t4_reg0", 32'(d), 32'h22);

        // 5: burst read wrapping, preload reg[1] first
        i2c_start();
        write_byte(8'hA0, ack); write_byte(8'h01, ack); write_byte(8'h3C, ack);
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, ack); write_byte(8'h0F, ack);
        i2c_start();
        write_byte(8'hA1, ack); chk("t5_ack_rd", 32'(ack), 32'd0);
        read_byte(d, 1'b0); chk("t5_rd0", 32'(d), 32'h11);
        read_byte(d, 1'b0); chk("t5_rd1", 32'(d), 32'h22);
        read_byte(d, 1'b1); chk("t5_rd2", 32'(d), 32'h3C);
        wq();
        chk("t5_busy_nack", 32'(busy), 32'd0);
        i2c_stop(); wq();
        chk("t5_sda_idle", 32'(sda_bus), 32'd1);

        // 6a: STOP after 4 data bits
        n0 = wr_cnt;
        i2c_start();
        write_byte(8'hA0, ack); write_byte(8'h03, ack);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        i2c_stop(); wq();
        chk("t6a_wr_count", 32'(wr_cnt - n0), 32'd0);
        peek(4'd3, d); chk("t6a_reg3", 32'(d), 32'hA5);
        chk("t6a_busy", 32'(busy), 32'd0);
        chk("t6a_sda", 32'(sda_bus), 32'd1);

        // 6b: reset after 5 data bits
        n0 = wr_cnt;
        i2c_start();
        write_byte(8'hA0, ack); write_byte(8'h03, ack);
        for (int i = 0; i < 5; i++) write_bit(1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_oe = 1'b0; scl = 1'b1;
        wq(); wq();
        chk("t6b_wr_count", 32'(wr_cnt - n0), 32'd0);
        peek(4'd3, d); chk("t6b_reg3", 32'(d), 32'h00);
        peek(4'd15, d); chk("t6b_reg15", 32'(d), 32'h00);
        chk("t6b_busy", 32'(busy), 32'd0);
        chk("t6b_sda", 32'(sda_bus), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
